// File: rtl/ni_local_tx_if.sv
// Flit handshake bundle between the leaf-router switch, the local-port
// transmitter and the PE network interface. The master modport is the
// transmitter itself; the slave modport is its environment.
`ifndef ROUTER_WIDTH
`define ROUTER_WIDTH 16
`endif

interface ni_local_tx_if;
  logic                     sw_valid;
  logic [`ROUTER_WIDTH-1:0] sw_data;
  logic                     sw_rdy;
  logic                     out_data_valid;
  logic [`ROUTER_WIDTH-1:0] out_data;
  logic                     downstream_credit;

  modport master (
    input  sw_valid,
    input  sw_data,
    input  downstream_credit,
    output sw_rdy,
    output out_data_valid,
    output out_data
  );

  modport slave (
    output sw_valid,
    output sw_data,
    output downstream_credit,
    input  sw_rdy,
    input  out_data_valid,
    input  out_data
  );
endinterface

// File: rtl/ni_local_tx.sv
// Local-port transmitter: circular flit buffer drained toward the NI under
// credit-based flow control. A flit leaves only when the buffer holds one and
// the NI has advertised a free slot; the output pair is registered.
`ifndef ROUTER_WIDTH
`define ROUTER_WIDTH 16
`endif

module ni_local_tx #(
  parameter int FIFO_DEPTH  = 4,
  parameter int CREDIT_INIT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  ni_local_tx_if.master                 bus,
  output logic [3:0]                    credit_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          credit_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = `ROUTER_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [3:0]    CINIT_C = 4'(CREDIT_INIT);

  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [DW-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [3:0]    credit_cnt_q, credit_cnt_d;
  logic          credit_err_q, credit_err_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;

  logic          full_s;
  logic          push_s;
  logic          send_s;

  // Ready depends only on registered occupancy, so a send never opens a slot
  // for a push in the same cycle.
  always_comb begin
    full_s = (fifo_cnt_q == DEPTH_C);
    push_s = bus.sw_valid && !full_s;
    send_s = (fifo_cnt_q != {CW{1'b0}}) && (credit_cnt_q != 4'd0);
  end

  // Next-state computation for buffer, pointers, counters and output register.
  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_cnt_d   = fifo_cnt_q;
    credit_cnt_d = credit_cnt_q;
    credit_err_d = credit_err_q;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;

    if (push_s) begin
      mem_d[wr_ptr_q] = bus.sw_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (send_s) begin
      out_data_d  = mem_q[rd_ptr_q];
      out_valid_d = 1'b1;
      rd_ptr_d    = rd_ptr_q + PW'(1);
    end else begin
      out_valid_d = 1'b0;
    end

    case ({push_s, send_s})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    // A returned credit with every NI slot already free is a protocol error:
    // saturate rather than wrap, and latch the error until reset.
    case ({send_s, bus.downstream_credit})
      2'b10:   credit_cnt_d = credit_cnt_q - 4'd1;
      2'b01: begin
        if (credit_cnt_q == CINIT_C) begin
          credit_cnt_d = credit_cnt_q;
          credit_err_d = 1'b1;
        end else begin
          credit_cnt_d = credit_cnt_q + 4'd1;
        end
      end
      default: credit_cnt_d = credit_cnt_q;
    endcase
  end

  // State registers; reset discards buffered flits and kills any flit in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {DW{1'b0}};
      end
      wr_ptr_q     <= {PW{1'b0}};
      rd_ptr_q     <= {PW{1'b0}};
      fifo_cnt_q   <= {CW{1'b0}};
      credit_cnt_q <= CINIT_C;
      credit_err_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= {DW{1'b0}};
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      credit_cnt_q <= credit_cnt_d;
      credit_err_q <= credit_err_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  assign bus.sw_rdy         = !full_s;
  assign bus.out_data_valid = out_valid_q;
  assign bus.out_data       = out_data_q;
  assign credit_cnt         = credit_cnt_q;
  assign fifo_cnt           = fifo_cnt_q;
  assign credit_err         = credit_err_q;

endmodule

// File: doc/ni_local_tx.md
# ni_local_tx

Router-side transmitter for the local port of a leaf quadtree router: buffers flits arriving from the router switch and delivers them to the PE network interface using credit-based flow control. It drives the `in_data_valid`/`in_data` pair the network interface consumes, and it counts the `upstream_credit` pulses that interface returns. It is the sending end of the NI input protocol and sits between the leaf-router crossbar output and the NI.

## Interface
- `FIFO_DEPTH`, 4, local flit buffer entries; power of two, ≥2.
- `CREDIT_INIT`, 4, credits after reset; equals the NI input buffer depth; 1..15.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  system reset; asynchronous, active-high.
- `sw_valid`  input  1  flit offered by the router switch.
- `sw_data`  input  `` `ROUTER_WIDTH ``  flit from the switch.
- `sw_rdy`  output  1  buffer can accept a flit.
- `out_data_valid`  output  1  flit valid toward the NI; registered.
- `out_data`  output  `` `ROUTER_WIDTH ``  flit toward the NI; registered.
- `downstream_credit`  input  1  single-cycle pulse from the NI; each pulse frees one NI slot.
- `credit_cnt`  output  4  current credit count.
- `fifo_cnt`  output  $clog2(FIFO_DEPTH)+1  current buffer occupancy.
- `credit_err`  output  1  sticky credit-overflow flag.

## Operation
- **Push:** a push occurs when `sw_valid && sw_rdy`. `sw_rdy = (fifo_cnt != FIFO_DEPTH)`. It depends only on registered state; there is no bypass.
- **FIFO structure:** circular buffer with write and read pointers of $clog2(FIFO_DEPTH) bits, wrapping modulo FIFO_DEPTH. Occupancy is a separate counter.
- **Send condition:** `send = (fifo_cnt != 0) && (credit_cnt != 0)`.
- **On send:**
  - the head entry is registered into `out_data`;
  - `out_data_valid` is registered to 1;
  - the read pointer advances.
- **When not sending:** `out_data_valid` is registered to 0 and `out_data` holds its last value.
- **Credit counter updates:**
  - send only: decrement by 1;
  - credit pulse only: increment by 1;
  - send and credit pulse in the same cycle: unchanged.
- **Credit overflow:** a pulse when `credit_cnt == CREDIT_INIT` and there is no simultaneous send:
  - the counter stays at CREDIT_INIT (it saturates);
  - `credit_err` is set to 1 and remains set until reset.
- **Occupancy counter updates:** push and send in the same cycle leave it unchanged. Push only gives +1; send only gives −1.
- **Full buffer with a concurrent send:** `sw_rdy` was already 0 in that cycle, so no push is accepted. `sw_rdy` returns to 1 in the next cycle.
- **Credit limit:** at most one flit is sent per cycle. No more than CREDIT_INIT flits are ever outstanding.
- **State machine:** none beyond the counters. The block is purely pointer/credit driven.

## Timing
- **Reset values (asynchronous assert):**
  - `out_data_valid` = 0, `out_data` = 0;
  - `credit_cnt` = CREDIT_INIT, `fifo_cnt` = 0, `credit_err` = 0;
  - pointers = 0, so `sw_rdy` = 1.
- **Reset mid-operation:** buffered flits are discarded. An `out_data_valid` in flight is forced low immediately.
- **Latency:** a flit pushed in cycle t into an empty buffer, with credit available, appears on `out_data_valid` in cycle t+2. There is one cycle in the buffer and one in the output register.
- **Throughput:** with continuous credit return, one flit per cycle sustained.
- **Credit effect:** a `downstream_credit` pulse in cycle t makes the credit usable for a send decision in cycle t+1.
- **Order:** flits leave in exactly the order accepted.

## Test plan
- **Single flit:** after reset, push 0x0A5 in cycle 1.
  - Required: `out_data_valid`=1 with `out_data`=0x0A5 in cycle 3.
  - Required: `credit_cnt` goes 4→3 and `fifo_cnt` returns to 0.
- **Credit exhaustion:** push 6 flits D0..D5 back-to-back with no credits returned.
  - Required: exactly D0..D3 are sent and `credit_cnt`=0.
  - Required: `fifo_cnt`=2 and the stream stalls.
  - Then one credit pulse: D4 is sent 2 cycles after the pulse.
- **Full buffer:** hold credits at 0 and push until `sw_rdy`=0 with `fifo_cnt`=4. A fifth `sw_valid` is not accepted.
  - Return one credit: `sw_rdy`=1 one cycle after the send.
  - Required: the later push is accepted and output ordering is preserved across pointer wrap.
- **Simultaneous send and credit:** with `credit_cnt`=1, pulse `downstream_credit` in the same cycle a send occurs.
  - Required: `credit_cnt` stays 1 and the next queued flit is sent the following cycle.
- **Overflow:** with `credit_cnt`=4 and the buffer empty, pulse credit.
  - Required: `credit_cnt` stays 4 and `credit_err`=1, and it stays set.
  - Reset clears it to 0.
- **Asynchronous reset mid-stream:** assert `rst` between clock edges while `out_data_valid`=1 and `fifo_cnt`=3.
  - Required: all outputs go to their reset values immediately.
  - Required: no stale flit appears after release.
